// File: rtl/service_display_arbiter.sv
// service_display_arbiter: arbitrates Service 1-4 ownership of the shared
// 4-digit 7-segment display, blanks it during owner hand-offs, scans the
// digits, blinks edit cursors and shows the clock when no service owns it.
// Ports:
//   clk, resetn    clock, synchronous active-high reset
//   svc_sel[3:0]   service switches, [3]=S1 .. [0]=S4
//   svc_num[63:0]  per-service BCD digits, [63:48]=S1 .. [15:0]=S4
//   svc_blink[15:0] per-service blink masks, [15:12]=S1 .. [3:0]=S4
//   clock_num[15:0] current time, shown when idle
//   grant[3:0]     one-hot owner (0 when none)
//   an[3:0]        one-hot digit enable, 4'b1000 = leftmost
//   seg[6:0]       segments {g,f,e,d,c,b,a}, active-high
//   switch_err     more than one switch on
module service_display_arbiter #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 125,
    parameter int HANDOFF   = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  svc_sel,
    input  logic [63:0] svc_num,
    input  logic [15:0] svc_blink,
    input  logic [15:0] clock_num,
    output logic [3:0]  grant,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        switch_err
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = (HANDOFF   > 1) ? $clog2(HANDOFF)   : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_OWN
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [3:0]    r_own;
    logic [3:0]    w_own_nx;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_nx;

    logic [SW-1:0] r_div;
    logic [1:0]    r_digit;
    logic [BW-1:0] r_round;
    logic          r_phase;

    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_err;

    logic [2:0]    w_cnt;
    logic          w_single;
    logic          w_div_wrap;
    logic          w_round_wrap;
    logic [15:0]   w_src;
    logic [3:0]    w_mask;
    logic [3:0]    w_nib;
    logic          w_mbit;
    logic [3:0]    w_an_nx;
    logic [6:0]    w_seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign w_cnt = {2'b00, svc_sel[3]} + {2'b00, svc_sel[2]}
                 + {2'b00, svc_sel[1]} + {2'b00, svc_sel[0]};
    assign w_single = (w_cnt == 3'd1);

    // Owner is sticky while its own switch stays on; the BLANK target is
    // re-chosen from the switches on the terminal hand-off cycle.
    always_comb begin
        w_state_nx = r_state;
        w_own_nx   = r_own;
        w_hcnt_nx  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_single) w_state_nx = ST_BLANK;
            end
            ST_OWN: begin
                if ((svc_sel & r_own) == 4'b0000) w_state_nx = ST_BLANK;
            end
            ST_BLANK: begin
                if (r_hcnt == HW'(HANDOFF - 1)) begin
                    if (w_single) begin
                        w_state_nx = ST_OWN;
                        w_own_nx   = svc_sel;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_hcnt_nx = r_hcnt + HW'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= ST_IDLE;
            r_own   <= 4'b0000;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_own   <= w_own_nx;
            r_hcnt  <= w_hcnt_nx;
        end
    end

    assign w_div_wrap   = (r_div == SW'(SCAN_DIV - 1));
    assign w_round_wrap = (r_round == BW'(BLINK_DIV - 1));

    // Scan timing is free-running; owner changes never disturb it.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_div   <= '0;
            r_digit <= 2'd0;
            r_round <= '0;
            r_phase <= 1'b0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + SW'(1);
            if (w_div_wrap) begin
                r_digit <= r_digit + 2'd1;
                if (r_digit == 2'd3) begin
                    r_round <= w_round_wrap ? '0 : r_round + BW'(1);
                    if (w_round_wrap) r_phase <= ~r_phase;
                end
            end
        end
    end

    always_comb begin
        w_src  = clock_num;
        w_mask = 4'b0000;
        if (r_state == ST_OWN) begin
            unique case (1'b1)
                r_own[3]: begin
                    w_src  = svc_num[63:48];
                    w_mask = svc_blink[15:12];
                end
                r_own[2]: begin
                    w_src  = svc_num[47:32];
                    w_mask = svc_blink[11:8];
                end
                r_own[1]: begin
                    w_src  = svc_num[31:16];
                    w_mask = svc_blink[7:4];
                end
                r_own[0]: begin
                    w_src  = svc_num[15:0];
                    w_mask = svc_blink[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nib  = w_src[15:12];
        w_mbit = w_mask[3];
        case (r_digit)
            2'd0: begin
                w_nib  = w_src[15:12];
                w_mbit = w_mask[3];
            end
            2'd1: begin
                w_nib  = w_src[11:8];
                w_mbit = w_mask[2];
            end
            2'd2: begin
                w_nib  = w_src[7:4];
                w_mbit = w_mask[1];
            end
            default: begin
                w_nib  = w_src[3:0];
                w_mbit = w_mask[0];
            end
        endcase
    end

    always_comb begin
        w_an_nx  = 4'b0000;
        w_seg_nx = 7'b0000000;
        if (r_state != ST_BLANK && !(r_phase && w_mbit)) begin
            w_an_nx  = 4'b1000 >> r_digit;
            w_seg_nx = seg7(w_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_an  <= 4'b0000;
            r_seg <= 7'b0000000;
            r_err <= 1'b0;
        end else begin
            r_an  <= w_an_nx;
            r_seg <= w_seg_nx;
            r_err <= (w_cnt > 3'd1);
        end
    end

    assign grant      = (r_state == ST_OWN) ? r_own : 4'b0000;
    assign an         = r_an;
    assign seg        = r_seg;
    assign switch_err = r_err;

endmodule

// File: tb/tb_service_display_arbiter.sv
// tb_service_display_arbiter: directed scenarios with an output-change
// scoreboard for service_display_arbiter (SCAN_DIV=4, BLINK_DIV=2, HANDOFF=8).
module tb_service_display_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  svc_sel;
    logic [63:0] svc_num;
    logic [15:0] svc_blink;
    logic [15:0] clock_num;
    logic [3:0]  grant;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        switch_err;

    service_display_arbiter #(
        .SCAN_DIV (4),
        .BLINK_DIV(2),
        .HANDOFF  (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .svc_sel   (svc_sel),
        .svc_num   (svc_num),
        .svc_blink (svc_blink),
        .clock_num (clock_num),
        .grant     (grant),
        .an        (an),
        .seg       (seg),
        .switch_err(switch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] SX = 7'b0000000;

    typedef struct {
        logic [15:0] v;
        int          hold;
    } exp_t;

    exp_t        q[$];
    exp_t        cur_exp;
    logic        mon_on;
    logic        have_prev;
    logic [15:0] prev;
    logic [15:0] cur;
    int          held;
    int          n_cmp;
    int          n_bad;
    string       stage;

    task automatic push(input logic [3:0] g, input logic [3:0] a,
                        input logic [6:0] s, input logic e,
                        input int h);
        exp_t x;
        x.v    = {g, a, s, e};
        x.hold = h;
        q.push_back(x);
    endtask

    // Each distinct output tuple is one transaction; the hold length of
    // the previous tuple is checked when it changes.
    always @(negedge clk) begin
        if (!mon_on) begin
            if (have_prev) begin
                n_cmp = n_cmp + 1;
                if (q.size() != 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s missing: got %0d tuples left, want 0",
                             stage, q.size());
                end
                q.delete();
            end
            have_prev = 1'b0;
        end else begin
            cur = {grant, an, seg, switch_err};
            if (!have_prev || cur !== prev) begin
                if (have_prev && cur_exp.hold >= 0) begin
                    n_cmp = n_cmp + 1;
                    if (held != cur_exp.hold) begin
                        n_bad = n_bad + 1;
                        $display("FAIL %s hold: got %0d cycles, want %0d",
                                 stage, held, cur_exp.hold);
                    end
                end
                n_cmp = n_cmp + 1;
                if (q.size() == 0) begin
                    n_bad = n_bad + 1;
                    cur_exp.hold = -1;
                    $display("FAIL %s extra: got g=%b an=%b seg=%b err=%b, want none",
                             stage, cur[15:12], cur[11:8], cur[7:1], cur[0]);
                end else begin
                    cur_exp = q.pop_front();
                    if (cur !== cur_exp.v) begin
                        n_bad = n_bad + 1;
                        $display("FAIL %s out: got g=%b an=%b seg=%b err=%b, want g=%b an=%b seg=%b err=%b",
                                 stage, cur[15:12], cur[11:8], cur[7:1], cur[0],
                                 cur_exp.v[15:12], cur_exp.v[11:8],
                                 cur_exp.v[7:1], cur_exp.v[0]);
                    end
                end
                prev      = cur;
                held      = 1;
                have_prev = 1'b1;
            end else begin
                held = held + 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1 mon_on = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b1;
        svc_sel   = 4'b0000;
        svc_num   = 64'h0;
        svc_blink = 16'h0;
        clock_num = 16'h0;
        mon_on    = 1'b0;
        have_prev = 1'b0;
        prev      = 16'h0;
        held      = 0;
        n_cmp     = 0;
        n_bad     = 0;
        cur_exp.v    = 16'h0;
        cur_exp.hold = -1;
        stage     = "init";

        stage = "reset_idle";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S1, 1'b0, 4);
        push(4'b0000, 4'b0100, S2, 1'b0, 4);
        push(4'b0000, 4'b0010, S3, 1'b0, 4);
        push(4'b0000, 4'b0001, S4, 1'b0, 4);
        push(4'b0000, 4'b1000, S1, 1'b0, -1);
        do_reset();
        svc_sel   = 4'b0000;
        clock_num = 16'h1234;
        run_edges(18);

        stage = "grant";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S0, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 7);
        push(4'b1000, 4'b0000, SX, 1'b0, 1);
        push(4'b1000, 4'b0010, S3, 1'b0, 3);
        push(4'b1000, 4'b0001, S0, 1'b0, 4);
        push(4'b1000, 4'b1000, S0, 1'b0, 4);
        push(4'b1000, 4'b0100, S8 & 7'b1101111, 1'b0, 4);
        push(4'b1000, 4'b0010, S3, 1'b0, -1);
        do_reset();
        clock_num = 16'h0000;
        svc_num   = {16'h0930, 48'h0};
        svc_blink = 16'h0;
        svc_sel   = 4'b1000;
        run_edges(26);

        stage = "blink";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S0, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 7);
        push(4'b0100, 4'b0000, SX, 1'b0, 1);
        push(4'b0100, 4'b0010, S7, 1'b0, 3);
        push(4'b0100, 4'b0001, S8, 1'b0, 4);
        push(4'b0100, 4'b1000, S5, 1'b0, 4);
        push(4'b0100, 4'b0100, S6, 1'b0, 4);
        push(4'b0100, 4'b0010, S7, 1'b0, 4);
        push(4'b0100, 4'b0001, S8, 1'b0, 4);
        push(4'b0100, 4'b1000, S5, 1'b0, 4);
        push(4'b0100, 4'b0100, S6, 1'b0, 4);
        push(4'b0100, 4'b0000, SX, 1'b0, 8);
        push(4'b0100, 4'b1000, S5, 1'b0, 4);
        push(4'b0100, 4'b0100, S6, 1'b0, 4);
        push(4'b0100, 4'b0000, SX, 1'b0, 8);
        push(4'b0100, 4'b1000, S5, 1'b0, 4);
        push(4'b0100, 4'b0100, S6, 1'b0, 4);
        push(4'b0100, 4'b0010, S7, 1'b0, -1);
        do_reset();
        clock_num = 16'h0000;
        svc_num   = {16'h0, 16'h5678, 32'h0};
        svc_blink = {4'h0, 4'b0011, 8'h0};
        svc_sel   = 4'b0100;
        run_edges(74);

        stage = "conflict";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S8, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 7);
        push(4'b1000, 4'b0000, SX, 1'b0, 1);
        push(4'b1000, 4'b0010, S8, 1'b0, 3);
        push(4'b1000, 4'b0001, S8, 1'b1, 4);
        push(4'b1000, 4'b1000, S8, 1'b1, 4);
        push(4'b0000, 4'b0100, S8, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 7);
        push(4'b0010, 4'b0000, SX, 1'b0, 1);
        push(4'b0010, 4'b0001, S8, 1'b0, 3);
        push(4'b0010, 4'b1000, S8, 1'b0, -1);
        do_reset();
        clock_num = 16'h8888;
        svc_num   = 64'h8888_8888_8888_8888;
        svc_blink = 16'h0;
        svc_sel   = 4'b1000;
        repeat (12) @(posedge clk);
        #1 svc_sel = 4'b1010;
        repeat (8) @(posedge clk);
        #1 svc_sel = 4'b0010;
        run_edges(14);

        stage = "invalid_digit";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S0, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 7);
        push(4'b0001, 4'b0000, SX, 1'b0, 1);
        push(4'b0001, 4'b0010, SX, 1'b0, 3);
        push(4'b0001, 4'b0001, S8, 1'b0, 4);
        push(4'b0001, 4'b1000, SX, 1'b0, 4);
        push(4'b0001, 4'b0100, S8, 1'b0, -1);
        do_reset();
        clock_num = 16'h0000;
        svc_num   = {48'h0, 16'hA8A8};
        svc_blink = 16'h0;
        svc_sel   = 4'b0001;
        run_edges(22);

        stage = "reset_in_blank";
        push(4'b0000, 4'b0000, SX, 1'b0, 3);
        push(4'b0000, 4'b1000, S1, 1'b0, 1);
        push(4'b0000, 4'b0000, SX, 1'b0, 4);
        push(4'b0000, 4'b1000, S1, 1'b0, 4);
        push(4'b0000, 4'b0100, S2, 1'b0, -1);
        do_reset();
        clock_num = 16'h1234;
        svc_num   = 64'h0;
        svc_sel   = 4'b1000;
        repeat (4) @(posedge clk);
        #1 resetn = 1'b1;
        svc_sel = 4'b0000;
        @(posedge clk);
        #1 resetn = 1'b0;
        run_edges(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/service_display_arbiter.md
# service_display_arbiter

Owns the shared 4-digit 7-segment display and decides which service drives it. It arbitrates among Service 1–4 from the debounced service switches and sequences clean hand-offs between owners. It time-multiplexes the four digits, applies per-service edit-cursor blinking, and shows the current time when no service is selected. It sits between the service modules and the board segment/anode pins, replacing the direct shared `num`/`an` drive.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit is lit per scan step (≥2).
- BLINK_DIV, 125: full scan rounds per blink half-period (≥1).
- HANDOFF, 1000: cycles the display is blanked during an owner change (≥1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  **synchronous, active-high reset (1 = reset)**, sampled on the rising edge of clk.
- svc_sel  in  4  debounced service switches; [3]=S1, [2]=S2, [1]=S3, [0]=S4.
- svc_num  in  64  per-service BCD digits; [63:48]=S1 … [15:0]=S4; within a service, [15:12] is the leftmost digit.
- svc_blink  in  16  per-service digit blink masks; [15:12]=S1 … [3:0]=S4; bit 3 = leftmost digit.
- clock_num  in  16  current time (BCD), displayed when idle.
- grant  out  4  one-hot current owner, same bit order as svc_sel; 0 when none.
- an  out  4  active-high one-hot digit enable; 4'b1000 = leftmost.
- seg  out  7  segment pattern for the lit digit, active-high, {g,f,e,d,c,b,a}.
- switch_err  out  1  more than one service switch is on.

## Operation
- sel_count = popcount(svc_sel).
- FSM states:
  - **IDLE**: grant=0; source=clock_num; no blink.
  - **BLANK**: grant=0; an=0.
  - **OWN(k)**: grant=one-hot k; source=svc_num slice k; blink mask = svc_blink slice k.
- FSM transitions:
  - IDLE: sel_count==1 → BLANK with target = that switch. sel_count>1 → stay IDLE.
  - OWN(k): svc_sel[k]==0 → BLANK. svc_sel[k]==1 → stay OWN(k) even if other switches are on; the owner is sticky.
  - BLANK: a hand-off counter runs 0..HANDOFF-1. On the terminal cycle, re-evaluate svc_sel: sel_count==1 → OWN(that switch); otherwise → IDLE. A target set on entry is not binding.
- Scan: a free-running divider runs 0..SCAN_DIV-1. On wrap, a 2-bit digit index increments 0→1→2→3→0. Index 0 = leftmost digit.
- Scan counters never reset on state changes; only resetn clears them.
- Blink: a round counter increments each time the digit index wraps 3→0. blink_phase toggles every BLINK_DIV rounds.
- In OWN, if blink_phase==1 and the mask bit for the current digit is 1, then an=0 and seg=0 for that step.
- Decode:
  - 0–9 use the standard patterns; 8 = 7'b1111111.
  - 10–15 give seg=0, with an still asserted.
- switch_err = (sel_count>1). It is registered and independent of the FSM.

## Timing
- Reset values: grant=0, an=0, seg=0, switch_err=0, state=IDLE. Scan divider, digit index, round counter, blink_phase and hand-off counter are all 0.
- Reset mid-operation (any state) behaves the same: on the next edge, everything returns to the reset values.
- svc_sel is sampled at edge N; the state and grant change at edge N; an, seg and switch_err reflect the new state at edge N+1.
- an and seg are registered together and are never mismatched within a cycle.
- Digit step: each an value holds exactly SCAN_DIV cycles. A full round is 4·SCAN_DIV cycles.
- BLANK lasts exactly HANDOFF cycles: grant is 0 from edge N through the terminal edge, and the new grant appears on the following edge.
- The owner switch dropping and another switch rising in the same cycle still passes through BLANK.
- svc_num, svc_blink and clock_num are sampled every cycle. Changes show at the next registered update with no lock.

## Test plan
Settings: SCAN_DIV=4, BLINK_DIV=2, HANDOFF=8.
- **Reset:** hold resetn=1 for 3 cycles → all outputs 0. Release with svc_sel=0, clock_num=16'h1234 → an steps 1000/0100/0010/0001, 4 cycles each, with seg 0000110/1011011/1001111/1100110.
- **Grant:** svc_sel=4'b1000, S1 num=16'h0930 → grant=0 and an=0 for 8 cycles. Then grant=4'b1000, and the leftmost step shows seg=0111111, the next shows 1101111.
- **Blink:** owner S2, mask 4'b0011 → digits 2–3 are lit in rounds 0–1 and dark (an=0, seg=0) in rounds 2–3, repeating. Digits 0–1 are always lit.
- **Conflict:** owner S1, raise S3 → grant stays 1000 and switch_err=1 one cycle later. Drop S1 → 8 cycles of BLANK, then grant=0010 and switch_err=0.
- **Invalid digit:** an owner digit of 4'hA → seg=0 while the corresponding an bit is 1.
- **Reset in BLANK:** assert resetn on hand-off cycle 3 → next edge gives state IDLE, all outputs 0, and an restarts at 1000 after release.
